// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Cycles per operation; guarded so a bad DIGIT reaches the elaboration check.
   function automatic int unsigned ncyc(input int unsigned width, input int unsigned digit);
      return (digit == 0) ? 1 : width / digit;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Full adder built from two 4:1 selections on {x, y}, with entries chosen by cin.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic co
);

   always_comb begin
      s  = 1'b0;
      co = 1'b0;
      unique case ({x, y})
         2'b00: begin s = cin;  co = 1'b0; end
         2'b01: begin s = ~cin; co = cin;  end
         2'b10: begin s = ~cin; co = cin;  end
         2'b11: begin s = cin;  co = 1'b1; end
         default: begin s = 1'b0; co = 1'b0; end
      endcase
   end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per cycle through a chain of fa_cells,
// carry registered between cycles, valid/ready handshake on both sides.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned NCYC  = ncyc(WIDTH, DIGIT);
   localparam int unsigned CNT_W = cnt_width(NCYC);

   if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   state_e state_q, state_d;

   logic [CNT_W-1:0]       cnt_q;
   logic [WIDTH-1:0]       opa_q, opb_q, res_q, sum_q;
   logic                   carry_q, cout_q, ovf_q;
   logic [DIGIT:0]         c;
   logic [DIGIT-1:0]       dsum;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]       res_next;
   logic                   last;

   assign c[0] = carry_q;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      fa_cell u_fa (
         .x   (opa_q[i]),
         .y   (opb_q[i]),
         .cin (c[i]),
         .s   (dsum[i]),
         .co  (c[i+1])
      );
   end

   // New digit enters at the MSB end; after NCYC shifts the result is aligned.
   assign res_cat  = {dsum, res_q};
   assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
   assign last     = (cnt_q == CNT_W'(NCYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid)  state_d = StRun;
         StRun:   if (last)      state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  opa_q   <= a;
                  opb_q   <= sub ? ~b : b;
                  carry_q <= sub;
                  cnt_q   <= '0;
               end
            end
            StRun: begin
               opa_q   <= opa_q >> DIGIT;
               opb_q   <= opb_q >> DIGIT;
               res_q   <= res_next;
               carry_q <= c[DIGIT];
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last) begin
                  sum_q  <= res_next;
                  cout_q <= c[DIGIT];
                  ovf_q  <= c[DIGIT] ^ c[DIGIT-1];
               end
            end
            default: ;
         endcase
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule
